// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS32 main controller:
// controller state enum, opcode field values and ALU operation classes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_BLEZ    = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } ctrl_state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  // The ALU decoder only looks at funct when aluop is ALUOP_RTYPE.
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_LEZ   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_XOR   = 3'b101;
  localparam logic [2:0] ALUOP_SLT   = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode classifier: state to enter after DECODE, plus the ALU class
// and extension mode for immediate-format instructions. Zero latency, no handshake.
module ctrl_opdec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  output ctrl_state_t dec_state,
  output logic [2:0]  imm_aluop,
  output logic        imm_zeroext
);

  always_comb begin
`ifdef ILLEGAL_TRAP_EN
    dec_state   = S_TRAP;
`else
    dec_state   = S_FETCH;
`endif
    imm_aluop   = ALUOP_ADD;
    imm_zeroext = 1'b0;
    case (opcode)
      OP_LW, OP_SW: dec_state = S_MEMADR;
      OP_R:         dec_state = S_RTYPEEX;
      OP_BEQ:       dec_state = S_BEQ;
      OP_BLEZ:      dec_state = S_BLEZ;
      OP_J:         dec_state = S_JUMP;
      OP_ADDI: begin
        dec_state = S_IMMEX;
        imm_aluop = ALUOP_ADD;
      end
      OP_SLTI: begin
        dec_state = S_IMMEX;
        imm_aluop = ALUOP_SLT;
      end
      OP_ORI: begin
        dec_state   = S_IMMEX;
        imm_aluop   = ALUOP_OR;
        imm_zeroext = 1'b1;
      end
      OP_XORI: begin
        dec_state   = S_IMMEX;
        imm_aluop   = ALUOP_XOR;
        imm_zeroext = 1'b1;
      end
      OP_LUI: begin
        dec_state = S_IMMEX;
        imm_aluop = ALUOP_LUI;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS32 core; memory states wait on mem_ready.
// ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP (illegal_instr=1) instead of running as NOP.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_lez,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  ctrl_state_t state_q, state_d;
  logic [5:0]  op_q, op_q_d;
  ctrl_state_t dec_state;
  logic [2:0]  imm_aluop;
  logic        imm_zeroext;

  // Decode classifies the live opcode; every later state sees the latched copy.
  always_comb begin
    op_q_d = op_q;
    if (state_q == S_DECODE) op_q_d = op;
  end

  ctrl_opdec u_opdec (
    .opcode      (op_q_d),
    .dec_state   (dec_state),
    .imm_aluop   (imm_aluop),
    .imm_zeroext (imm_zeroext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_q_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_lez = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        state_d = dec_state;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_RTYPE;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_BLEZ: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_LEZ;
        branch_lez = 1'b1;
        pcsrc      = 2'b01;
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = imm_aluop;
        zeroext = imm_zeroext;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset kills strobes immediately, even mid-access, not just at the next edge.
    if (!reset) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_lez = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      zeroext    = 1'b0;
      pcsrc      = 2'b00;
      aluop      = 3'b000;
`ifdef ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate bench: each instruction is expanded into its expected per-cycle
// control words from the instruction-level timing rules and compared at mid-cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BLEZ = 6'b000110, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, ORI = 6'b001101, XORI = 6'b001110;
  localparam logic [5:0] LUI = 6'b001111, J = 6'b000010;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_lez;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] op;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_lez;
  logic       regdst, memtoreg, regwrite, alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif
  ctl_t       got;
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] legal_ops [11];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .branch_lez(branch_lez), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always_comb begin
    got = '0;
    got.mem_req = mem_req;   got.iord = iord;         got.memwrite = memwrite;
    got.irwrite = irwrite;   got.pcwrite = pcwrite;   got.branch = branch;
    got.branch_lez = branch_lez; got.regdst = regdst; got.memtoreg = memtoreg;
    got.regwrite = regwrite; got.alusrca = alusrca;   got.alusrcb = alusrcb;
    got.zeroext = zeroext;   got.pcsrc = pcsrc;       got.aluop = aluop;
`ifdef ILLEGAL_TRAP_EN
    got.illegal = illegal_instr;
`endif
  end

  task automatic check_vec(input string tag, input ctl_t g, input ctl_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, g, e, $time);
    end
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // One clock: drive at the falling edge, check the combinational outputs 1ns later.
  task automatic step(input string tag, input logic rdy, input logic rst,
                      input logic [5:0] opv, input ctl_t e);
    @(negedge clk);
    mem_ready = rdy;
    reset     = rst;
    op        = opv;
    #1;
    check_vec(tag, got, e);
  endtask

  function automatic logic is_legal(input logic [5:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // fw/mw: wait cycles in fetch and in the data access; abort pulls reset during the access.
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input bit abort);
    ctl_t e;
    e = '0; e.mem_req = 1; e.alusrcb = 2'b01;
    for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, 1'b1, opc, e);
    e.irwrite = 1; e.pcwrite = 1;
    step("fetch", 1'b1, 1'b1, opc, e);
    e = '0; e.alusrcb = 2'b11;
    step("decode", rbit(), 1'b1, opc, e);
    case (opc)
      LW, SW: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        step("memadr", rbit(), 1'b1, junk(), e);
        e = '0; e.mem_req = 1; e.iord = 1; e.memwrite = (opc == SW);
        for (int i = 0; i < mw; i++) step("mem_wait", 1'b0, 1'b1, junk(), e);
        if (abort) begin
          step("mem_abort", rbit(), 1'b0, junk(), '0);
        end else begin
          step("mem_done", 1'b1, 1'b1, junk(), e);
          if (opc == LW) begin
            e = '0; e.regwrite = 1; e.memtoreg = 1;
            step("memwb", rbit(), 1'b1, junk(), e);
          end
        end
      end
      RT: begin
        e = '0; e.alusrca = 1; e.aluop = 3'b111;
        step("rtypeex", rbit(), 1'b1, junk(), e);
        e = '0; e.regwrite = 1; e.regdst = 1;
        step("aluwb", rbit(), 1'b1, junk(), e);
      end
      BEQ, BLEZ: begin
        e = '0; e.alusrca = 1; e.pcsrc = 2'b01;
        if (opc == BEQ) begin e.branch = 1; e.aluop = 3'b001; end
        else begin e.branch_lez = 1; e.aluop = 3'b010; end
        step("branch", rbit(), 1'b1, junk(), e);
      end
      ADDI, SLTI, ORI, XORI, LUI: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10;
        e.aluop = (opc == SLTI) ? 3'b110 : (opc == ORI) ? 3'b011 :
                  (opc == XORI) ? 3'b101 : (opc == LUI) ? 3'b100 : 3'b000;
        e.zeroext = (opc == ORI) || (opc == XORI);
        step("immex", rbit(), 1'b1, junk(), e);
        e = '0; e.regwrite = 1;
        step("immwb", rbit(), 1'b1, junk(), e);
      end
      J: begin
        e = '0; e.pcwrite = 1; e.pcsrc = 2'b10;
        step("jump", rbit(), 1'b1, junk(), e);
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        e = '0; e.illegal = 1;
        for (int i = 0; i < 4; i++) step("trap", rbit(), 1'b1, junk(), e);
        step("trap_reset", rbit(), 1'b0, junk(), '0);
`endif
      end
    endcase
  endtask

  initial begin
    logic [5:0] o;
    legal_ops = '{LW, SW, RT, BEQ, BLEZ, ADDI, SLTI, ORI, XORI, LUI, J};
    reset = 1'b0; mem_ready = 1'b0; op = 6'd0;
    step("reset0", 1'b1, 1'b0, LW, '0);
    step("reset1", 1'b1, 1'b0, SW, '0);

    run_instr(LW, 2, 2, 1'b0);
    run_instr(RT, 0, 0, 1'b0);
    run_instr(ORI, 0, 0, 1'b0);
    run_instr(XORI, 1, 0, 1'b0);
    run_instr(LUI, 0, 0, 1'b0);
    run_instr(BEQ, 0, 0, 1'b0);
    run_instr(BLEZ, 0, 0, 1'b0);
    run_instr(J, 0, 0, 1'b0);
    run_instr(ADDI, 0, 0, 1'b0);
    run_instr(SLTI, 0, 0, 1'b0);
    run_instr(SW, 0, 0, 1'b0);
    run_instr(SW, 0, 2, 1'b1);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(LW, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(11, 0) == 0) begin
        do o = junk(); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(10, 0)];
      end
      run_instr(o, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(7, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle MIPS32 core.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, memory port and register file.
- Generates `aluop[2:0]` for the ALU decoder; the ALU decoder resolves `funct` only when `aluop` = 3'b111 (R-type).
- Memory accesses use a `mem_req`/`mem_ready` handshake, so latency is variable.

Parameters:
- None.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- op  in  6  opcode field of instruction register (stable from DECODE to end of instruction)
- mem_ready  in  1  memory completes the current `mem_req` access this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe (qualified by `mem_req`)
- irwrite  out  1  load instruction register
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if ALU zero (beq)
- branch_lez  out  1  PC load if ALU result ≤ 0 (blez)
- regdst  out  1  write register: 1 = rd, 0 = rt
- memtoreg  out  1  write data: 1 = memory data, 0 = ALUOut
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
- zeroext  out  1  immediate zero-extend (ori/xori), else sign-extend
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  3  ALU operation class for the ALU decoder

Behaviour:
- **Reset.** While `reset` = 0 at a clk edge, state <= FETCH and latched opcode <= 0. While `reset` is low, every output is forced to 0. A reset asserted mid-instruction aborts it; `memwrite` and `regwrite` drop combinationally.
- **Opcodes.** lw 100011, sw 101011, R 000000, beq 000100, blez 000110, addi 001000, slti 001010, ori 001101, xori 001110, lui 001111, j 000010.
- **Outputs.** Outputs not listed for a state are 0.
- **FETCH:** `mem_req`=1, `alusrcb`=01, `aluop`=000.
  - `mem_ready`=1: `irwrite`=1, `pcwrite`=1, next DECODE.
  - `mem_ready`=0: stay; `irwrite`/`pcwrite` stay 0.
- **DECODE:** `alusrcb`=11, `aluop`=000 (branch target precompute). Latch `op` into `op_q`.
  - lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQ; blez -> BLEZ.
  - addi/slti/ori/xori/lui -> IMMEX; j -> JUMP.
  - Other opcodes: see Optional Feature.
- **MEMADR:** `alusrca`=1, `alusrcb`=10, `aluop`=000. lw -> MEMRD; sw -> MEMWR.
- **MEMRD:** `mem_req`=1, `iord`=1. Stay until `mem_ready`, then MEMWB.
- **MEMWB:** `regwrite`=1, `memtoreg`=1, `regdst`=0 -> FETCH.
- **MEMWR:** `mem_req`=1, `iord`=1, `memwrite`=1, all held until `mem_ready`, then FETCH.
- **RTYPEEX:** `alusrca`=1, `alusrcb`=00, `aluop`=111 -> ALUWB.
- **ALUWB:** `regwrite`=1, `regdst`=1 -> FETCH.
- **BEQ:** `alusrca`=1, `alusrcb`=00, `aluop`=001, `branch`=1, `pcsrc`=01 -> FETCH.
- **BLEZ:** `alusrca`=1, `alusrcb`=00, `aluop`=010, `branch_lez`=1, `pcsrc`=01 -> FETCH.
- **IMMEX:** `alusrca`=1, `alusrcb`=10 -> IMMWB.
  - `aluop` by `op_q`: addi 000, ori 011, lui 100, xori 101, slti 110.
  - `zeroext`=1 for ori/xori.
- **IMMWB:** `regwrite`=1, `regdst`=0, `memtoreg`=0 -> FETCH.
- **JUMP:** `pcwrite`=1, `pcsrc`=10 -> FETCH.
- **Cycle counts** (`mem_ready` = 1 immediately):
  - lw 5; sw 4; R-type 4; immediates 4; beq/blez/j 3.
- **Memory wait states.** Each cycle with `mem_ready`=0 adds exactly one cycle. A `mem_ready` pulse outside a `mem_req` state is ignored.
- **Decode source.** Only `op_q` drives decisions after DECODE; `op` changes after DECODE have no effect.

Optional Feature:
- Macro: `ILLEGAL_TRAP_EN`.
- **Defined:**
  - An unrecognised opcode in DECODE -> TRAP.
  - TRAP holds all outputs 0 forever and asserts extra output `illegal_instr`=1.
  - Only reset exits TRAP.
- **Not defined:**
  - An unrecognised opcode returns DECODE -> FETCH (executes as NOP).
  - No TRAP state and no `illegal_instr` port.

Decomposition:
- Package `mips_ctrl_pkg`:
  - state enum `ctrl_state_t` (4-bit).
  - opcode localparams (OP_LW…OP_J).
  - aluop localparams (ALUOP_ADD=000 … ALUOP_RTYPE=111).
- One sub-module, `ctrl_opdec`: combinational `op_q` -> next-state class, immediate `aluop`, `zeroext`. Instantiated once.

Test Plan:
- Reset low 2 cycles then lw, `mem_ready` low 2 cycles in FETCH and MEMRD -> FETCH 3 cycles, `irwrite`/`pcwrite` pulse once; MEMWB `regwrite`=1, `memtoreg`=1; total 9 cycles.
- R-type `op`=000000 -> RTYPEEX `aluop`=111, ALUWB `regdst`=1 `regwrite`=1; back in FETCH cycle 5.
- ori then xori then lui -> IMMEX `aluop` 011/101/100, `zeroext` 1/1/0, `alusrcb`=10.
- beq and blez -> single-cycle `branch`/`branch_lez`=1, `pcsrc`=01, `aluop` 001/010.
- sw with `reset` pulled low during MEMWR wait -> `memwrite` 0 same cycle; FETCH next.
- `op`=111111 -> with `ILLEGAL_TRAP_EN`, `illegal_instr`=1 and stuck; without it, FETCH after 2 cycles with no writes.
